// File: rtl/ffs_pkg.sv
// rtl/ffs_pkg.sv - shared types for the find-first-set round-robin arbiter
package ffs_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ffs_tree.sv
// rtl/ffs_tree.sv - log-depth find-first-set, returns position of first set bit counted from the MSB
module ffs_tree #(
  parameter int W = 8
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx
);

  localparam int IW = $clog2(W);

  // Heap-ordered binary tree: leaf W+k holds vec[W-1-k]; left child wins ties.
  // An empty vector falls through to the rightmost leaf, i.e. all ones.
  function automatic logic [IW-1:0] first_from_msb(input logic [W-1:0] v);
    logic          nv [2*W];
    logic [IW-1:0] ni [2*W];
    nv[0] = 1'b0;
    ni[0] = '0;
    for (int k = 0; k < W; k++) begin
      nv[W+k] = v[W-1-k];
      ni[W+k] = IW'(k);
    end
    for (int n = W - 1; n >= 1; n--) begin
      nv[n] = nv[2*n] | nv[2*n+1];
      ni[n] = nv[2*n] ? ni[2*n] : ni[2*n+1];
    end
    return ni[1];
  endfunction

  assign idx = first_from_msb(vec);

endmodule

// File: rtl/ffs_rr_arbiter.sv
// rtl/ffs_rr_arbiter.sv - round-robin arbiter with quantum-limited hold and registered one-hot grant
module ffs_rr_arbiter
  import ffs_pkg::*;
#(
  parameter int N_REQ   = 8,
  parameter int QUANTUM = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_gnt_valid,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rev;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W-1:0] winner;
  logic             any_cand;
  logic             own_req;
  logic             take;
  logic             drop;

  // The current owner is masked out; in IDLE o_gnt is zero so nothing is masked.
  assign cand     = i_req & ~o_gnt;
  assign any_cand = |cand;
  assign own_req  = |(i_req & o_gnt);

  // Rotate so ptr lands at rotated index 0, then bit-reverse so index 0 is the MSB.
  always_comb begin
    rev = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rev[N_REQ-1-i] = cand[ptr + IDX_W'(i)];
    end
  end

  ffs_tree #(
    .W(N_REQ)
  ) u_ffs (
    .vec(rev),
    .idx(rot_idx)
  );

  assign winner = ptr + rot_idx;

  assign take = any_cand && ((state == ARB_IDLE) || !own_req || (cnt == CNT_MAX));
  assign drop = (state == ARB_GRANT) && !own_req && !any_cand;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      o_gnt       <= '0;
      o_gnt_valid <= 1'b0;
      o_gnt_id    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (take) begin
            state       <= ARB_GRANT;
            o_gnt       <= N_REQ'(1) << winner;
            o_gnt_valid <= 1'b1;
            o_gnt_id    <= winner;
            ptr         <= winner + IDX_W'(1);
            cnt         <= CNT_ONE;
          end
        end
        ARB_GRANT: begin
          if (take) begin
            o_gnt    <= N_REQ'(1) << winner;
            o_gnt_id <= winner;
            ptr      <= winner + IDX_W'(1);
            cnt      <= CNT_ONE;
          end else if (drop) begin
            state       <= ARB_IDLE;
            o_gnt       <= '0;
            o_gnt_valid <= 1'b0;
            o_gnt_id    <= '0;
            cnt         <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state       <= ARB_IDLE;
          o_gnt       <= '0;
          o_gnt_valid <= 1'b0;
          o_gnt_id    <= '0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ffs_rr_arbiter.md
FFS_RR_ARBITER -- requirements
Module: ffs_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 8, giving the number of requesters (power of 2, >= 2).
REQ-002 The block SHALL have parameter QUANTUM, default 16, giving the maximum consecutive grant cycles before preemption (>= 1).
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port i_req, input, N_REQ bits, level request where bit k is requester k.
REQ-006 The block SHALL have port o_gnt, output, N_REQ bits, a registered one-hot grant, all zeros when nobody is granted.
REQ-007 The block SHALL have port o_gnt_valid, output, 1 bit, high exactly when o_gnt is non-zero.
REQ-008 The block SHALL have port o_gnt_id, output, $clog2(N_REQ) bits, the binary index of the granted requester, 0 when o_gnt_valid is low.

Function
REQ-009 The block SHALL keep a priority pointer ptr ($clog2(N_REQ) bits) and a hold counter cnt (enough bits to hold QUANTUM).
REQ-010 The winner from a candidate vector SHALL be the first set bit searching index ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
REQ-011 The FSM SHALL have two states: IDLE (no grant) and GRANT (owner g = o_gnt_id).
REQ-012 In IDLE with i_req non-zero at an edge, that edge SHALL register the grant to the winner, enter GRANT and set cnt=1; latency is one edge, with no combinational path from i_req to outputs.
REQ-013 In IDLE with i_req zero, the block SHALL stay in IDLE and leave the outputs at zero.
REQ-014 In GRANT, if i_req[g]=0 (release) and other bits are set, the same edge SHALL grant the winner of i_req with bit g masked, with no idle bubble, and set cnt=1.
REQ-015 In GRANT, if i_req[g]=0 and no other bit is set, the block SHALL go to IDLE at that edge.
REQ-016 In GRANT, if i_req[g]=1, cnt=QUANTUM and another bit is set, the block SHALL preempt g at that edge by granting the masked winner and setting cnt=1.
REQ-017 In GRANT, if i_req[g]=1 and no other bit is set, the grant SHALL hold and cnt SHALL saturate at QUANTUM.
REQ-018 In GRANT, if i_req[g]=1 and cnt<QUANTUM, the grant SHALL hold and cnt SHALL increment.
REQ-019 Every new grant to winner w SHALL set ptr=(w+1) mod N_REQ, wrapping from N_REQ-1 to 0; ptr SHALL be unchanged otherwise.
REQ-020 A request dropped before being granted SHALL have no effect on ptr, cnt or the outputs.
REQ-021 The winner search SHALL be evaluated only in the edge that issues a grant; o_gnt SHALL never have more than one bit set.

Reset
REQ-022 On i_rst_n low, the block SHALL immediately and without a clock set o_gnt=0, o_gnt_valid=0, o_gnt_id=0, ptr=0, cnt=0 and state=IDLE.
REQ-023 On i_rst_n low mid-grant, the block SHALL abort the grant; after deassertion, the first edge SHALL arbitrate from ptr=0.
REQ-024 Reset deassertion SHALL be synchronized externally; the block SHALL not add a synchronizer.

Structure
REQ-025 A shared package ffs_pkg SHALL hold the FSM state enum typedef (ARB_IDLE, ARB_GRANT).
REQ-026 Winner selection SHALL instantiate the existing ffs_tree sub-module on the rotated, masked request vector, bit-reversed so that the search index is MSB-first.
REQ-027 The rotated index SHALL be added to ptr modulo N_REQ.
REQ-028 The all-ones ffs result SHALL not be trusted; the empty case SHALL be detected by a separate OR-reduce.
REQ-029 All outputs SHALL be driven directly from flops.

Verification (N_REQ=8, QUANTUM=4)
REQ-030 Scenario: reset, then i_req=8'h00 for 10 cycles -> o_gnt=0, o_gnt_valid=0 and o_gnt_id=0 throughout.
REQ-031 Scenario: from reset, i_req=8'b0010_0100 -> after one edge o_gnt_id=2; then clear bit 2 -> the next edge gives o_gnt_id=5 with no cycle of o_gnt_valid=0.
REQ-032 Scenario: i_req=8'b1000_0001 held -> o_gnt_id=0 for 4 cycles, then 7 for 4 cycles, then 0, repeating with no gaps.
REQ-033 Scenario: i_req=8'b0000_1000 held 50 cycles -> o_gnt_id=3 continuously and cnt stays at 4.
REQ-034 Scenario: grant id 7 released while i_req=8'b1000_0001 with bit 7 now low -> next o_gnt_id=0 (ptr wrapped to 0).
REQ-035 Scenario: i_rst_n pulled low between clock edges during a grant -> o_gnt=0 before the next edge; after release with i_req=8'hFF -> first o_gnt_id=0.
